data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Load/store responder for a RISC-V style core: word RAM with byte lanes and a
// fixed two-cycle response. Define OUTPORT_EN to map word 0xFFFC to inport/outport.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   input  logic [31:0] inport,
   output logic [31:0] outport
);

   localparam int AW = $clog2(DEPTH_WORDS);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]  state;
   logic        vld_p1;

   logic [15:0] addr_p0;
   logic        we_p0;
   logic [2:0]  funct3_p0;
   logic [31:0] wdata_p0;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0] rd_p1;
   logic        err_p1;
   logic        we_p1;
   logic [2:0]  funct3_p1;
   logic [1:0]  lane_p1;

   logic [AW-1:0] idx;
   logic          acc_err;
   logic [3:0]    wr_be;
   logic [31:0]   wr_data;
   logic          io_hit;

   function automatic logic access_err(input logic we, input logic [2:0] f3,
                                       input logic [1:0] a);
      case (f3)
         3'b000:  return 1'b0;
         3'b100:  return we;
         3'b001:  return a[0];
         3'b101:  return we | a[0];
         3'b010:  return a != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   return 4'b0001 << a;
         2'b01:   return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b100:  return {24'd0, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b101:  return {16'd0, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   assign req_ready = (state == S_IDLE);
   assign idx       = addr_p0[AW+1:2];
   assign acc_err   = access_err(we_p0, funct3_p0, addr_p0[1:0]);
   assign wr_be     = byte_enables(funct3_p0, addr_p0[1:0]);
   assign wr_data   = store_lanes(funct3_p0, wdata_p0);

`ifdef OUTPORT_EN
   assign io_hit = (addr_p0[15:2] == 14'h3FFF);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outport <= '0;
      end else if (state == S_ACCESS && we_p0 && !acc_err && io_hit) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) outport[8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   logic unused_bits;
   assign unused_bits = ^{req_addr[31:16], addr_p0};
`else
   assign io_hit  = 1'b0;
   assign outport = '0;

   logic unused_bits;
   assign unused_bits = ^{req_addr[31:16], addr_p0, inport};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         vld_p1     <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         vld_p1 <= 1'b0;
         case (state)
            S_IDLE:   if (req_valid) state <= S_ACCESS;
            S_ACCESS: begin
               state  <= S_RESP;
               vld_p1 <= 1'b1;
            end
            S_RESP:   if (resp_valid && resp_ready) begin
               state      <= S_IDLE;
               resp_valid <= 1'b0;
            end
            default:  state <= S_IDLE;
         endcase
         // Format stage: RAM word is settled, extend it into the response
         if (vld_p1) begin
            resp_valid <= 1'b1;
            resp_err   <= err_p1;
            resp_rdata <= (err_p1 || we_p1) ? 32'd0 : load_extend(rd_p1, funct3_p1, lane_p1);
         end
      end
   end

   // Request capture on the accept edge
   always_ff @(posedge clk) begin
      if (req_valid && req_ready) begin
         addr_p0   <= req_addr[15:0];
         we_p0     <= req_we;
         funct3_p0 <= req_funct3;
         wdata_p0  <= req_wdata;
      end
   end

   // Access stage: synchronous RAM read and byte-lane write
   always_ff @(posedge clk) begin
      if (state == S_ACCESS) begin
         rd_p1     <= io_hit ? inport : mem[idx];
         err_p1    <= acc_err;
         we_p1     <= we_p0;
         funct3_p1 <= funct3_p0;
         lane_p1   <= addr_p0[1:0];
         if (we_p0 && !acc_err && !io_hit) begin
            for (int i = 0; i < 4; i++) begin
               if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic against
// a byte-array reference model. Honours OUTPORT_EN when defined.
module tb_data_mem_responder;

   localparam int DEPTH = 256;
   localparam int NBYTES = DEPTH * 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] inport;
   logic [31:0] outport;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem_b [NBYTES];
   logic [7:0] out_b [4];

   data_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_funct3 (req_funct3),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .inport     (inport),
      .outport    (outport)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_outport();
      return {out_b[3], out_b[2], out_b[1], out_b[0]};
   endfunction

   // Reference: byte-addressed memory, access size from funct3, alignment by modulo
   task automatic model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, output logic [31:0] rd, output logic e);
      int n;
      int base;
      logic io;
      logic [31:0] v;
      rd = 32'd0;
      io = 1'b0;
`ifdef OUTPORT_EN
      io = (addr[15:2] == 14'h3FFF);
`endif
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      base = int'(addr[15:0]);
      e = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]) || (base % n != 0);
      if (e) return;
      if (we) begin
         for (int k = 0; k < n; k++) begin
            if (io) out_b[(base + k) % 4] = wd[8*k +: 8];
            else    mem_b[(base + k) % NBYTES] = wd[8*k +: 8];
         end
         return;
      end
      v = 32'd0;
      for (int k = 0; k < n; k++) begin
         if (io) v[8*k +: 8] = inport[8*((base + k) % 4) +: 8];
         else    v[8*k +: 8] = mem_b[(base + k) % NBYTES];
      end
      if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
      rd = v;
   endtask

   // One request/response exchange; lat counts clock edges from accept to resp_valid
   task automatic transact(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] wd, input int hold,
                           output logic [31:0] rd, output logic err, output int lat);
      @(negedge clk);
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_funct3 = f3;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rd  = resp_rdata;
      err = resp_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      chk("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
   endtask

   task automatic run(input string tag, input logic we, input logic [31:0] addr,
                      input logic [2:0] f3, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic err);
      logic [31:0] exp_rd;
      logic exp_e;
      int lat;
      model(we, addr, f3, wd, exp_rd, exp_e);
      transact(we, addr, f3, wd, hold, rd, err, lat);
      chk({tag, "_lat"}, 32'(lat), 32'd2);
      chk({tag, "_rdata"}, rd, exp_rd);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_e});
      chk({tag, "_outport"}, outport, model_outport());
   endtask

   initial begin
      logic [31:0] rd;
      logic err;
      logic [31:0] hold_rd;
      logic hold_err;
      int lat;
      logic [31:0] a;
      logic [31:0] w;

      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = '0;
      req_funct3 = '0;
      req_wdata = '0;
      resp_ready = 1'b0;
      inport = 32'h0;
      for (int i = 0; i < 4; i++) out_b[i] = 8'h00;
      #3;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_outport", outport, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int wi = 0; wi < DEPTH; wi++) begin
         run("init", 1'b1, 32'(wi * 4), 3'b010, $urandom, 0, rd, err);
      end

      run("st_word", 1'b1, 32'h0010, 3'b010, 32'hDEADBEEF, 0, rd, err);
      chk("st_word_rd0", rd, 32'd0);
      run("ld_word", 1'b0, 32'h0010, 3'b010, 32'h0, 0, rd, err);
      chk("ld_word_val", rd, 32'hDEADBEEF);
      run("ld_byte", 1'b0, 32'h0013, 3'b000, 32'h0, 1, rd, err);
      chk("ld_byte_val", rd, 32'hFFFFFFDE);
      run("ld_byteu", 1'b0, 32'h0013, 3'b100, 32'h0, 0, rd, err);
      chk("ld_byteu_val", rd, 32'h000000DE);
      run("ld_half", 1'b0, 32'h0010, 3'b001, 32'h0, 2, rd, err);
      chk("ld_half_val", rd, 32'hFFFFBEEF);
      run("st_half", 1'b1, 32'h0012, 3'b001, 32'h00001234, 0, rd, err);
      run("ld_merge", 1'b0, 32'h0010, 3'b010, 32'h0, 0, rd, err);
      chk("ld_merge_val", rd, 32'h1234BEEF);
      run("st_misal", 1'b1, 32'h0011, 3'b010, 32'hCAFEF00D, 0, rd, err);
      chk("st_misal_err", {31'd0, err}, 32'd1);
      run("ld_after_misal", 1'b0, 32'h0010, 3'b010, 32'h0, 0, rd, err);
      chk("ld_after_misal_val", rd, 32'h1234BEEF);
      run("ld_illegal", 1'b0, 32'h0010, 3'b011, 32'h0, 0, rd, err);
      chk("ld_illegal_err", {31'd0, err}, 32'd1);
      run("st_byteu", 1'b1, 32'h0010, 3'b100, 32'h0, 0, rd, err);
      chk("st_byteu_err", {31'd0, err}, 32'd1);
      run("ld_alias", 1'b0, 32'hABCD0410, 3'b010, 32'h0, 0, rd, err);
      chk("ld_alias_val", rd, 32'h1234BEEF);

      // Response stall: outputs frozen while resp_ready stays low
      @(negedge clk);
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = 32'h0010;
      req_funct3 = 3'b010;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("stall_lat", 32'(lat), 32'd2);
      hold_rd = resp_rdata;
      hold_err = resp_err;
      chk("stall_rd", hold_rd, 32'h1234BEEF);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("stall_valid", {31'd0, resp_valid}, 32'd1);
         chk("stall_rdata", resp_rdata, hold_rd);
         chk("stall_err", {31'd0, resp_err}, {31'd0, hold_err});
         chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      chk("stall_release", {31'd0, req_ready}, 32'd1);

`ifdef OUTPORT_EN
      run("io_st_byte", 1'b1, 32'h0000FFFC, 3'b000, 32'h0000005A, 0, rd, err);
      chk("io_outport", outport, 32'h0000005A);
      inport = 32'h80000001;
      run("io_ld_word", 1'b0, 32'h0000FFFC, 3'b010, 32'h0, 0, rd, err);
      chk("io_ld_val", rd, 32'h80000001);
`else
      run("alias_st", 1'b1, 32'h1234FFFC, 3'b010, 32'h0BADF00D, 0, rd, err);
      chk("alias_outport", outport, 32'd0);
      run("alias_ld", 1'b0, 32'h000003FC, 3'b010, 32'h0, 0, rd, err);
      chk("alias_ld_val", rd, 32'h0BADF00D);
`endif

      // Reset while the request sits in ACCESS
      @(negedge clk);
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = 32'h0010;
      req_funct3 = 3'b010;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("midrst_outport", outport, 32'd0);
      for (int i = 0; i < 4; i++) out_b[i] = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
      run("post_rst", 1'b0, 32'h0010, 3'b010, 32'h0, 0, rd, err);
      chk("post_rst_val", rd, 32'h1234BEEF);

      for (int t = 0; t < 300; t++) begin
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a[15:2] = 14'h3FFF;
         w = $urandom;
         inport = $urandom;
         run("rand", 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), w,
             int'($urandom_range(0, 3)), rd, err);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
